// File: rtl/dispense_sequencer_if.sv
// Dispense sequencer port bundle: button and portion code in, servo and status out.
// Latency: none, pure wiring between the sequencer and its controller/observer.
// Backpressure: none; the button is an unsynchronised level and the outputs are plain levels/pulses.
interface dispense_sequencer_if;
   logic       i_dispense;    // raw active-low button, asynchronous to the clock
   logic [1:0] i_control;     // portion code 0..2 (3 is ignored)
   logic       o_servo_pwm;   // registered servo drive
   logic       o_gate_open;   // gate commanded open
   logic       o_busy;        // dispense cycle in progress
   logic       o_done;        // one-cycle completion pulse

   // The sequencer itself
   modport slave (
      input  i_dispense,
      input  i_control,
      output o_servo_pwm,
      output o_gate_open,
      output o_busy,
      output o_done
   );

   // Whoever drives the button and watches the status
   modport master (
      output i_dispense,
      output i_control,
      input  o_servo_pwm,
      input  o_gate_open,
      input  o_busy,
      input  o_done
   );
endinterface

// File: rtl/dispense_sequencer.sv
// Hopper gate sequencer: one open/close/settle cycle per falling edge of the dispense button, plus servo PWM.
// Latency: busy/gate_open rise on the 3rd clock edge after the first edge that samples the button low.
// Backpressure: none; button edges arriving while busy (or in the done cycle) are dropped, never queued.
module dispense_sequencer #(
   parameter int PWM_PERIOD    = 1_000_000,
   parameter int PULSE_CLOSED  = 50_000,
   parameter int PULSE_OPEN    = 100_000,
   parameter int UNIT_CYCLES   = 25_000_000,
   parameter int SETTLE_CYCLES = 25_000_000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   dispense_sequencer_if.slave   bus
);

   // FSM encoding
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_OPEN   = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;

   // Open/settle durations computed at 64 bits so the 3-unit product cannot overflow
   localparam longint unsigned C_OPEN1_L  = longint'(UNIT_CYCLES);
   localparam longint unsigned C_OPEN2_L  = longint'(UNIT_CYCLES) * 2;
   localparam longint unsigned C_OPEN3_L  = longint'(UNIT_CYCLES) * 3;
   localparam longint unsigned C_SETTLE_L = longint'(SETTLE_CYCLES);

   // One timer serves both phases, so it must hold whichever load is larger
   localparam longint unsigned C_TMAX = (C_OPEN3_L > C_SETTLE_L) ? C_OPEN3_L : C_SETTLE_L;
   localparam int TW = (C_TMAX > 1) ? $clog2(C_TMAX + 1) : 1;

   // Frame counter runs 0..PWM_PERIOD-1; pulse widths are below PWM_PERIOD so they fit too
   localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

   localparam logic [TW-1:0] C_OPEN1  = TW'(C_OPEN1_L);
   localparam logic [TW-1:0] C_OPEN2  = TW'(C_OPEN2_L);
   localparam logic [TW-1:0] C_OPEN3  = TW'(C_OPEN3_L);
   localparam logic [TW-1:0] C_SETTLE = TW'(C_SETTLE_L);
   localparam logic [TW-1:0] C_T_ONE  = TW'(1);

   localparam logic [PW-1:0] C_PWM_LAST     = PW'(PWM_PERIOD - 1);
   localparam logic [PW-1:0] C_PULSE_OPEN   = PW'(PULSE_OPEN);
   localparam logic [PW-1:0] C_PULSE_CLOSED = PW'(PULSE_CLOSED);

   // Button synchroniser and edge detector
   logic          r_sync1;
   logic          r_sync2;
   logic          r_prev;
   logic          w_fall;

   // Sequencer state
   logic [1:0]    r_state;
   logic [TW-1:0] r_timer;
   logic          r_done;
   logic [TW-1:0] w_open_load;
   logic          w_accept;
   logic          w_timer_last;

   // Servo PWM
   logic [PW-1:0] r_pwm_cnt;
   logic [PW-1:0] r_pwm_width;
   logic          r_pwm;

   // Two-flop synchroniser plus previous-value flop; idle level of the button is high
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= bus.i_dispense;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_fall = r_prev & ~r_sync2;

   // Open time for the requested portion; the timer load is the only place control is used
   always_comb begin
      w_open_load = C_OPEN1;
      case (bus.i_control)
         2'd0:    w_open_load = C_OPEN1;
         2'd1:    w_open_load = C_OPEN2;
         default: w_open_load = C_OPEN3;
      endcase
   end

   // An edge is taken only in IDLE, with a legal code, and not in the done cycle
   assign w_accept     = w_fall && !r_done && (bus.i_control != 2'd3);
   assign w_timer_last = (r_timer <= C_T_ONE);

   // Sequencer FSM: timer counts the remaining cycles of the current phase
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_OPEN;
                  r_timer <= w_open_load;
               end
            end
            S_OPEN: begin
               if (w_timer_last) begin
                  r_state <= S_SETTLE;
                  r_timer <= C_SETTLE;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            S_SETTLE: begin
               if (w_timer_last) begin
                  r_state <= S_IDLE;
                  r_timer <= '0;
                  r_done  <= 1'b1;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_timer <= '0;
            end
         endcase
      end
   end

   // Free-running servo frame; width only changes at the wrap so every frame is whole
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_pwm_cnt   <= '0;
         r_pwm_width <= C_PULSE_CLOSED;
         r_pwm       <= 1'b0;
      end else begin
         r_pwm <= (r_pwm_cnt < r_pwm_width);
         if (r_pwm_cnt == C_PWM_LAST) begin
            r_pwm_cnt   <= '0;
            r_pwm_width <= (r_state == S_OPEN) ? C_PULSE_OPEN : C_PULSE_CLOSED;
         end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
         end
      end
   end

   // Status decodes straight off the state register, so reset clears them asynchronously
   assign bus.o_servo_pwm = r_pwm;
   assign bus.o_gate_open = (r_state == S_OPEN);
   assign bus.o_busy      = (r_state == S_OPEN) || (r_state == S_SETTLE);
   assign bus.o_done      = r_done;

endmodule
